// File: rtl/sys_array_mac_nxn_if.sv
// Operand/result bundle for the N x N systolic matrix multiplier.
// The requester drives operands and start; the array returns C with busy/done status.
interface sys_array_mac_nxn_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic                      start;
    logic                      acc_en;
    logic [N*N*DATA_W-1:0]     a_flat;
    logic [N*N*DATA_W-1:0]     b_flat;
    logic [N*N*ACC_W-1:0]      c_flat;
    logic                      busy;
    logic                      done;

    modport master (
        output start, acc_en, a_flat, b_flat,
        input  c_flat, busy, done
    );

    modport slave (
        input  start, acc_en, a_flat, b_flat,
        output c_flat, busy, done
    );
endinterface

// File: rtl/sys_array_mac_nxn.sv
// Output-stationary N x N systolic matrix multiplier: C = A*B, or C += A*B when acc_en is set.
// Operands enter skewed at the left/top edges and march right/down one PE per cycle.
module sys_array_mac_nxn #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    sys_array_mac_nxn_if.slave bus
);
    localparam int               CNT_W    = $clog2(3 * N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3 * N - 3);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_d;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    logic [DATA_W-1:0] a_op     [N][N];
    logic [DATA_W-1:0] b_op     [N][N];
    logic [DATA_W-1:0] a_edge   [N];
    logic [DATA_W-1:0] b_edge   [N];
    logic [DATA_W-1:0] a_in     [N][N];
    logic [DATA_W-1:0] b_in     [N][N];
    logic [DATA_W-1:0] a_pass   [N][N];
    logic [DATA_W-1:0] b_pass   [N][N];
    logic [ACC_W-1:0]  prod_ext [N][N];
    logic [ACC_W-1:0]  acc      [N][N];

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN:     if (cnt == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            if (accept)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + 1'b1;
        end
    end

    // Row i sees A[i][cnt-i] and column j sees B[cnt-j][j]; the skew lines up matching k at PE(i,j).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
        end
        if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(cnt) == i + k) a_edge[i] = a_op[i][k];
                    if (int'(cnt) == i + k) b_edge[i] = b_op[k][i];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_edge[i];
            end else begin : g_a_link
                assign a_in[i][j] = a_pass[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b_edge[j];
            end else begin : g_b_link
                assign b_in[i][j] = b_pass[i-1][j];
            end

            if (SIGNED != 0) begin : g_smul
                logic signed [2*DATA_W-1:0] prod;
                assign prod           = $signed(a_in[i][j]) * $signed(b_in[i][j]);
                assign prod_ext[i][j] = ACC_W'(prod);
            end else begin : g_umul
                logic [2*DATA_W-1:0] prod;
                assign prod           = a_in[i][j] * b_in[i][j];
                assign prod_ext[i][j] = ACC_W'(prod);
            end
        end
    end

    // Pass registers are cleared on accept so leftovers from the previous run never reach a PE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_op[i][j]   <= '0;
                    b_op[i][j]   <= '0;
                    a_pass[i][j] <= '0;
                    b_pass[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_op[i][j]   <= bus.a_flat[(i*N+j)*DATA_W +: DATA_W];
                    b_op[i][j]   <= bus.b_flat[(i*N+j)*DATA_W +: DATA_W];
                    a_pass[i][j] <= '0;
                    b_pass[i][j] <= '0;
                    if (!bus.acc_en) acc[i][j] <= '0;
                end
            end
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pass[i][j] <= a_in[i][j];
                    b_pass[i][j] <= b_in[i][j];
                    acc[i][j]    <= acc[i][j] + prod_ext[i][j];
                end
            end
        end
    end

    always_comb begin
        bus.c_flat = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                bus.c_flat[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_sys_array_mac_nxn.sv
// Self-checking bench: three array configurations checked against a plain matrix-product model.
// Covers latency, busy/done timing, accumulate, wraparound, signed math, held start and mid-run reset.
module tb_sys_array_mac_nxn;
    typedef longint mat_t [8][8];

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    mat_t exp3, exp4, exp2, ma, mb;

    always #5 clk = ~clk;

    sys_array_mac_nxn_if #(.N(3), .DATA_W(8), .ACC_W(20)) if3 ();
    sys_array_mac_nxn_if #(.N(4), .DATA_W(8), .ACC_W(20)) if4 ();
    sys_array_mac_nxn_if #(.N(2), .DATA_W(8), .ACC_W(20)) if2 ();

    sys_array_mac_nxn #(.N(3), .DATA_W(8), .ACC_W(20), .SIGNED(0)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    sys_array_mac_nxn #(.N(4), .DATA_W(8), .ACC_W(20), .SIGNED(0)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    sys_array_mac_nxn #(.N(2), .DATA_W(8), .ACC_W(20), .SIGNED(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic void zero(output mat_t m);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m[i][j] = 0;
    endfunction

    // Reference: C[i][j] = (acc ? C[i][j] : 0) + sum_k A[i][k]*B[k][j], modulo 2^20.
    function automatic void model(input int n, input mat_t a, input mat_t b, input bit accumulate,
                                  inout mat_t c);
        longint s;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = accumulate ? c[i][j] : 0;
                for (int k = 0; k < n; k++) s += a[i][k] * b[k][j];
                c[i][j] = s & 64'hFFFFF;
            end
        end
    endfunction

    task automatic rand_mat(input int n, input bit sgn, output mat_t m);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m[i][j] = (i < n && j < n) ? longint'($urandom_range(0, 255)) - (sgn ? 128 : 0) : 0;
    endtask

    function automatic logic [511:0] pack(input int n, input mat_t m);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                v[(i*n+j)*8 +: 8] = 8'(m[i][j]);
        return v;
    endfunction

    function automatic logic [511:0] rand_bits();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            3:       return if3.busy;
            4:       return if4.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            3:       return if3.done;
            4:       return if4.done;
            default: return if2.done;
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input logic ac,
                         input logic [511:0] af, input logic [511:0] bf);
        case (w)
            3: begin
                if3.start = st; if3.acc_en = ac; if3.a_flat = af[71:0];  if3.b_flat = bf[71:0];
            end
            4: begin
                if4.start = st; if4.acc_en = ac; if4.a_flat = af[127:0]; if4.b_flat = bf[127:0];
            end
            default: begin
                if2.start = st; if2.acc_en = ac; if2.a_flat = af[31:0];  if2.b_flat = bf[31:0];
            end
        endcase
    endtask

    task automatic read_c(input int w, output logic [1279:0] c);
        c = '0;
        case (w)
            3:       c[179:0] = if3.c_flat;
            4:       c[319:0] = if4.c_flat;
            default: c[79:0]  = if2.c_flat;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic checkMatrix(input string tag, input int w, input int n, input mat_t expc);
        logic [1279:0] c;
        logic [19:0]   got, want;
        read_c(w, c);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                got  = c[(i*n+j)*20 +: 20];
                want = 20'(expc[i][j]);
                checkOutput($sformatf("%s.c[%0d][%0d]", tag, i, j), 32'(got), 32'(want));
            end
        end
    endtask

    // Presents operands with start for one accept edge; hold keeps start asserted afterwards.
    task automatic applyStimulus(input int w, input int n, input mat_t a, input mat_t b,
                                 input bit ac, input bit hold);
        drive(w, 1'b1, ac, pack(n, a), pack(n, b));
        @(posedge clk); #1;
        if (!hold) drive(w, 1'b0, ac, pack(n, a), pack(n, b));
    endtask

    // Counts cycles from the accept edge to done; disturb scrambles the bus and pulses start mid-run.
    task automatic wait_done(input int w, input bit disturb, output int cyc, output int busy_cyc);
        busy_cyc = get_busy(w) ? 1 : 0;
        cyc      = 0;
        while (!get_done(w) && cyc < 100) begin
            if (disturb && cyc == 1) drive(w, 1'b1, 1'b1, rand_bits(), rand_bits());
            if (disturb && cyc == 2) drive(w, 1'b0, 1'b0, rand_bits(), rand_bits());
            @(posedge clk); #1;
            cyc++;
            if (get_busy(w)) busy_cyc++;
        end
    endtask

    task automatic check_run(input string tag, input int w, input int n, input mat_t a, input mat_t b,
                             input bit ac, input bit disturb, inout mat_t expc);
        int cyc, bc;
        applyStimulus(w, n, a, b, ac, 1'b0);
        wait_done(w, disturb, cyc, bc);
        model(n, a, b, ac, expc);
        checkOutput({tag, ".latency"}, 32'(cyc), 32'(3*n-2));
        checkOutput({tag, ".busy_cycles"}, 32'(bc), 32'(3*n-2));
        checkMatrix(tag, w, n, expc);
        @(posedge clk); #1;
        checkOutput({tag, ".done_width"}, 32'(get_done(w)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, bc, seen;

        rst = 1'b1;
        drive(3, 1'b0, 1'b0, '0, '0);
        drive(4, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        zero(exp3); zero(exp4); zero(exp2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset.busy3", 32'(if3.busy), 32'd0);
        checkOutput("reset.done3", 32'(if3.done), 32'd0);
        checkOutput("reset.busy4", 32'(if4.busy), 32'd0);
        checkOutput("reset.done2", 32'(if2.done), 32'd0);
        checkMatrix("reset3", 3, 3, exp3);
        checkMatrix("reset4", 4, 4, exp4);
        checkMatrix("reset2", 2, 2, exp2);

        zero(ma); zero(mb);
        for (int i = 0; i < 3; i++) begin
            ma[i][i] = 1;
            for (int j = 0; j < 3; j++) mb[i][j] = i*3 + j + 1;
        end
        check_run("ident", 3, 3, ma, mb, 1'b0, 1'b0, exp3);

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = i*3 + j + 1;
                mb[i][j] = 9 - (i*3 + j);
            end
        check_run("seq", 3, 3, ma, mb, 1'b0, 1'b1, exp3);
        check_run("seq_acc", 3, 3, ma, mb, 1'b1, 1'b0, exp3);

        for (int r = 0; r < 3; r++) begin
            rand_mat(3, 1'b0, ma); rand_mat(3, 1'b0, mb);
            check_run($sformatf("rnd3_%0d", r), 3, 3, ma, mb, 1'($urandom_range(0, 1)), 1'b1, exp3);
        end

        zero(ma);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) ma[i][j] = 255;
        check_run("max4", 4, 4, ma, ma, 1'b0, 1'b0, exp4);
        for (int r = 0; r < 4; r++)
            check_run($sformatf("wrap4_%0d", r), 4, 4, ma, ma, 1'b1, 1'b0, exp4);
        rand_mat(4, 1'b0, ma); rand_mat(4, 1'b0, mb);
        check_run("rnd4", 4, 4, ma, mb, 1'b1, 1'b1, exp4);

        zero(ma); zero(mb);
        ma[0][0] = -1; ma[0][1] = 2;  ma[1][0] = 3; ma[1][1] = -4;
        mb[0][0] = 5;  mb[0][1] = -6; mb[1][0] = 7; mb[1][1] = 8;
        applyStimulus(2, 2, ma, mb, 1'b0, 1'b1);
        wait_done(2, 1'b0, cyc, bc);
        model(2, ma, mb, 1'b0, exp2);
        checkOutput("hold.latency", 32'(cyc), 32'd4);
        checkMatrix("signed", 2, 2, exp2);
        @(posedge clk); #1;
        checkOutput("hold.idle_gap", 32'(if2.busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("hold.reaccept", 32'(if2.busy), 32'd1);
        drive(2, 1'b0, 1'b0, pack(2, ma), pack(2, mb));
        wait_done(2, 1'b0, cyc, bc);
        model(2, ma, mb, 1'b0, exp2);
        checkOutput("hold.latency2", 32'(cyc), 32'd4);
        checkMatrix("hold2", 2, 2, exp2);
        @(posedge clk); #1;

        for (int r = 0; r < 3; r++) begin
            rand_mat(2, 1'b1, ma); rand_mat(2, 1'b1, mb);
            check_run($sformatf("rnd2s_%0d", r), 2, 2, ma, mb, 1'($urandom_range(0, 1)), 1'b1, exp2);
        end

        rand_mat(3, 1'b0, ma); rand_mat(3, 1'b0, mb);
        applyStimulus(3, 3, ma, mb, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        zero(exp3); zero(exp4); zero(exp2);
        checkOutput("abort.busy", 32'(if3.busy), 32'd0);
        checkMatrix("abort", 3, 3, exp3);
        checkMatrix("abort4", 4, 4, exp4);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if3.done) seen++;
        end
        checkOutput("abort.no_done", 32'(seen), 32'd0);

        rand_mat(3, 1'b0, ma); rand_mat(3, 1'b0, mb);
        check_run("acc_after_rst", 3, 3, ma, mb, 1'b1, 1'b0, exp3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
